// File: rtl/uart_prog_loader.sv
// UART programmer loader: parses a 2-byte little-endian word count, then packs
// payload bytes into 32-bit little-endian words for the program ROM write port.
module uart_prog_loader #(
    parameter int TIMEOUT_CYCLES = 1_000_000,
    parameter int MAX_WORDS      = 16384
) (
    input  logic        upg_clk_i,
    input  logic        upg_rst_i,
    input  logic        rx_valid_i,
    input  logic [7:0]  rx_data_i,
    output logic        upg_wen_o,
    output logic [13:0] upg_adr_o,
    output logic [31:0] upg_dat_o,
    output logic        upg_done_o,
    output logic        upg_err_o
);

    localparam int IW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {HDR0, HDR1, DATA, DONE, ERR} state_t;

    state_t        state, state_nxt;
    logic [15:0]   cnt;
    logic [14:0]   word_idx;
    logic [1:0]    byte_idx;
    logic [23:0]   part;
    logic [IW-1:0] idle;

    logic        timing;
    logic        timeout_hit;
    logic        accept;
    logic [15:0] hdr_cnt;
    logic        hdr_bad;
    logic [14:0] last_idx;
    logic        word_end;

    assign timing      = (state == HDR1) || (state == DATA);
    // Once the idle counter saturates the transfer is dead; a byte arriving
    // in that same cycle is too late and is dropped.
    assign timeout_hit = timing && (idle == IW'(TIMEOUT_CYCLES));
    assign accept      = rx_valid_i && !timeout_hit;
    assign hdr_cnt     = {rx_data_i, cnt[7:0]};
    assign hdr_bad     = (hdr_cnt == 16'd0) || ({16'd0, hdr_cnt} > 32'(MAX_WORDS));
    // 15-bit compare lets a count of 16384 finish at index 16383.
    assign last_idx    = 15'(cnt - 16'd1);
    assign word_end    = (state == DATA) && accept && (byte_idx == 2'd3);

    always_comb begin
        state_nxt = state;
        case (state)
            HDR0: if (accept) state_nxt = HDR1;
            HDR1: begin
                if (timeout_hit)
                    state_nxt = ERR;
                else if (accept)
                    state_nxt = hdr_bad ? ERR : DATA;
            end
            DATA: begin
                if (timeout_hit)
                    state_nxt = ERR;
                else if (word_end && (word_idx == last_idx))
                    state_nxt = DONE;
            end
            DONE:    state_nxt = DONE;
            ERR:     state_nxt = ERR;
            default: state_nxt = HDR0;
        endcase
    end

    always_ff @(posedge upg_clk_i) begin
        if (upg_rst_i) begin
            state      <= HDR0;
            cnt        <= '0;
            word_idx   <= '0;
            byte_idx   <= '0;
            part       <= '0;
            idle       <= '0;
            upg_wen_o  <= 1'b0;
            upg_adr_o  <= '0;
            upg_dat_o  <= '0;
            upg_done_o <= 1'b0;
            upg_err_o  <= 1'b0;
        end else begin
            state     <= state_nxt;
            upg_wen_o <= 1'b0;

            if (!timing || accept)
                idle <= '0;
            else if (idle != IW'(TIMEOUT_CYCLES))
                idle <= idle + 1'b1;

            case (state)
                HDR0: if (accept) cnt[7:0] <= rx_data_i;
                HDR1: begin
                    if (accept) begin
                        cnt[15:8] <= rx_data_i;
                        word_idx  <= '0;
                        byte_idx  <= '0;
                    end
                end
                DATA: begin
                    if (accept) begin
                        byte_idx <= byte_idx + 2'd1;
                        case (byte_idx)
                            2'd0: part[7:0]   <= rx_data_i;
                            2'd1: part[15:8]  <= rx_data_i;
                            2'd2: part[23:16] <= rx_data_i;
                            default: begin
                                upg_dat_o <= {rx_data_i, part};
                                upg_adr_o <= word_idx[13:0];
                                upg_wen_o <= 1'b1;
                                word_idx  <= word_idx + 15'd1;
                            end
                        endcase
                    end
                end
                default: ;
            endcase

            // Flags follow the registered state, so done trails the last
            // write strobe by one cycle.
            upg_done_o <= (state == DONE);
            upg_err_o  <= (state == ERR) || timeout_hit;
        end
    end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Self-checking bench for uart_prog_loader: write-port traffic is collected by a
// monitor and compared against words predicted from the byte stream.
module tb_uart_prog_loader;
    localparam int TO = 100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        wen;
    logic [13:0] adr;
    logic [31:0] dat;
    logic        done;
    logic        err;

    int tests = 0;
    int fails = 0;

    logic [13:0] wadr_q[$];
    logic [31:0] wdat_q[$];
    logic [7:0]  pay[$];

    always #5 clk = ~clk;

    uart_prog_loader #(.TIMEOUT_CYCLES(TO), .MAX_WORDS(16384)) dut (
        .upg_clk_i (clk),
        .upg_rst_i (rst),
        .rx_valid_i(rx_valid),
        .rx_data_i (rx_data),
        .upg_wen_o (wen),
        .upg_adr_o (adr),
        .upg_dat_o (dat),
        .upg_done_o(done),
        .upg_err_o (err)
    );

    always @(negedge clk) begin
        if (wen) begin
            wadr_q.push_back(adr);
            wdat_q.push_back(dat);
        end
    end

    // Reference: word k is payload bytes 4k..4k+3, least significant first.
    function automatic logic [31:0] exp_word(input int k);
        return 32'(pay[4*k]) + (32'(pay[4*k+1]) << 8) +
               (32'(pay[4*k+2]) << 16) + (32'(pay[4*k+3]) << 24);
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic do_reset();
        rx_valid = 1'b0;
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        wadr_q.delete();
        wdat_q.delete();
        pay.delete();
    endtask

    task automatic test_reset();
        tick(2);
        rst = 1'b0;
        tests++;
        if ({wen, adr, dat, done, err} !== 49'd0) begin
            fails++;
            $display("FAIL reset_outputs: got wen=%b adr=%h dat=%h done=%b err=%b want all 0",
                     wen, adr, dat, done, err);
        end
    endtask

    task automatic test_single();
        do_reset();
        send(8'h01); send(8'h00);
        send(8'h78); send(8'h56); send(8'h34); send(8'h12);
        tests++;
        if (wen !== 1'b1 || adr !== 14'd0 || dat !== 32'h12345678) begin
            fails++;
            $display("FAIL single_strobe: got wen=%b adr=%h dat=%h want 1/0000/12345678", wen, adr, dat);
        end
        tests++;
        if (done !== 1'b0) begin
            fails++;
            $display("FAIL single_done_early: got done=%b want 0", done);
        end
        tick(1);
        tests++;
        if (done !== 1'b1 || wen !== 1'b0 || err !== 1'b0) begin
            fails++;
            $display("FAIL single_done: got done=%b wen=%b err=%b want 1/0/0", done, wen, err);
        end
        tests++;
        if (wdat_q.size() != 1) begin
            fails++;
            $display("FAIL single_count: got %0d writes want 1", wdat_q.size());
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        send(8'h03); send(8'h00);
        for (int i = 0; i < 12; i++) begin
            pay.push_back(8'(i));
            send(8'(i));
        end
        tick(2);
        for (int i = 0; i < 5; i++) send(8'(8'hA0 + i));
        tick(2);
        tests++;
        if (wdat_q.size() != 3) begin
            fails++;
            $display("FAIL b2b_count: got %0d writes want 3", wdat_q.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                tests++;
                if (wadr_q[k] !== 14'(k) || wdat_q[k] !== exp_word(k)) begin
                    fails++;
                    $display("FAIL b2b_word%0d: got adr=%h dat=%h want adr=%h dat=%h",
                             k, wadr_q[k], wdat_q[k], 14'(k), exp_word(k));
                end
            end
        end
        tests++;
        if (done !== 1'b1 || err !== 1'b0) begin
            fails++;
            $display("FAIL b2b_done: got done=%b err=%b want 1/0", done, err);
        end
    endtask

    task automatic test_hdr_err();
        logic [15:0] hdrs [2];
        hdrs[0] = 16'h0000;
        hdrs[1] = 16'h4001;
        for (int h = 0; h < 2; h++) begin
            do_reset();
            send(hdrs[h][7:0]);
            send(hdrs[h][15:8]);
            tests++;
            if (err !== 1'b0) begin
                fails++;
                $display("FAIL hdr_err_early%0d: got err=%b want 0", h, err);
            end
            tick(1);
            tests++;
            if (err !== 1'b1) begin
                fails++;
                $display("FAIL hdr_err%0d: got err=%b want 1", h, err);
            end
            for (int i = 0; i < 8; i++) send(8'(i));
            tick(2);
            tests++;
            if (wdat_q.size() != 0 || done !== 1'b0 || err !== 1'b1) begin
                fails++;
                $display("FAIL hdr_err_quiet%0d: got writes=%0d done=%b err=%b want 0/0/1",
                         h, wdat_q.size(), done, err);
            end
        end
    endtask

    task automatic test_timeout();
        int waited;
        do_reset();
        send(8'h02); send(8'h00);
        for (int i = 0; i < 6; i++) begin
            pay.push_back(8'($urandom_range(0, 255)));
            send(pay[i]);
        end
        tick(TO - 2);
        tests++;
        if (err !== 1'b0) begin
            fails++;
            $display("FAIL timeout_early: got err=%b want 0", err);
        end
        waited = 0;
        while (err !== 1'b1 && waited < 8) begin
            tick(1);
            waited++;
        end
        tests++;
        if (err !== 1'b1) begin
            fails++;
            $display("FAIL timeout_err: got err=%b want 1 within %0d cycles", err, TO + 6);
        end
        tests++;
        if (wdat_q.size() != 1 || done !== 1'b0) begin
            fails++;
            $display("FAIL timeout_writes: got writes=%0d done=%b want 1/0", wdat_q.size(), done);
        end else begin
            tests++;
            if (wadr_q[0] !== 14'd0 || wdat_q[0] !== exp_word(0)) begin
                fails++;
                $display("FAIL timeout_word: got adr=%h dat=%h want 0000/%h", wadr_q[0], wdat_q[0], exp_word(0));
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        send(8'h01); send(8'h00);
        send(8'hAA); send(8'hBB);
        rx_valid = 1'b1;
        rx_data  = 8'hCC;
        rst = 1'b1;
        tick(1);
        rx_valid = 1'b0;
        rst = 1'b0;
        tests++;
        if ({wen, adr, dat, done, err} !== 49'd0) begin
            fails++;
            $display("FAIL reset_mid_outputs: got wen=%b adr=%h dat=%h done=%b err=%b want all 0",
                     wen, adr, dat, done, err);
        end
        wadr_q.delete();
        wdat_q.delete();
        pay.delete();
        send(8'h01); send(8'h00);
        for (int i = 0; i < 4; i++) begin
            pay.push_back(8'($urandom_range(0, 255)));
            send(pay[i]);
        end
        tick(2);
        tests++;
        if (wdat_q.size() != 1 || done !== 1'b1) begin
            fails++;
            $display("FAIL reset_mid_count: got writes=%0d done=%b want 1/1", wdat_q.size(), done);
        end else begin
            tests++;
            if (wadr_q[0] !== 14'd0 || wdat_q[0] !== exp_word(0)) begin
                fails++;
                $display("FAIL reset_mid_word: got adr=%h dat=%h want 0000/%h", wadr_q[0], wdat_q[0], exp_word(0));
            end
        end
    endtask

    task automatic test_random();
        int n;
        for (int it = 0; it < 3; it++) begin
            do_reset();
            n = $urandom_range(1, 8);
            send(8'(n)); send(8'h00);
            for (int i = 0; i < 4 * n; i++) begin
                pay.push_back(8'($urandom_range(0, 255)));
                send(pay[i]);
                if ($urandom_range(0, 1) == 1) tick($urandom_range(1, 4));
            end
            for (int i = 0; i < $urandom_range(0, 4); i++) send(8'($urandom_range(0, 255)));
            tick(3);
            tests++;
            if (wdat_q.size() != n || done !== 1'b1 || err !== 1'b0) begin
                fails++;
                $display("FAIL random%0d_count: got writes=%0d done=%b err=%b want %0d/1/0",
                         it, wdat_q.size(), done, err, n);
            end else begin
                for (int k = 0; k < n; k++) begin
                    tests++;
                    if (wadr_q[k] !== 14'(k) || wdat_q[k] !== exp_word(k)) begin
                        fails++;
                        $display("FAIL random%0d_word%0d: got adr=%h dat=%h want adr=%h dat=%h",
                                 it, k, wadr_q[k], wdat_q[k], 14'(k), exp_word(k));
                    end
                end
            end
        end
    endtask

    task automatic test_full();
        int bad;
        do_reset();
        send(8'h00); send(8'h40);
        for (int i = 0; i < 65536; i++) begin
            pay.push_back(8'((i * 7 + 3) % 256));
            send(pay[i]);
        end
        tick(3);
        tests++;
        if (wdat_q.size() != 16384 || done !== 1'b1 || err !== 1'b0) begin
            fails++;
            $display("FAIL full_count: got writes=%0d done=%b err=%b want 16384/1/0",
                     wdat_q.size(), done, err);
        end else begin
            bad = 0;
            for (int k = 0; k < 16384; k++)
                if (wadr_q[k] !== 14'(k) || wdat_q[k] !== exp_word(k)) bad++;
            tests++;
            if (bad != 0) begin
                fails++;
                $display("FAIL full_words: got %0d bad words want 0", bad);
            end
            tests++;
            if (wadr_q[16383] !== 14'h3FFF) begin
                fails++;
                $display("FAIL full_last_adr: got %h want 3fff", wadr_q[16383]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_hdr_err();
        test_timeout();
        test_reset_mid();
        test_random();
        test_full();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
